spu_cmd_sequencer: RTL
======================

// Module: spu_cmd_sequencer
// PURPOSE
//   Byte-serial command front end for the tiny SPU datapath. Collects a header byte plus
//   operand bytes from the dedicated input pins, issues one datapath operation, waits for
//   completion with a timeout, then returns the result MSB-first with a byte handshake.
//   Sits between the top-level pin wrapper (ui_in/uio_in/uo_out) and the SPU ALU core.
// PARAMETERS
//   DATA_W       16   operand/result width; must be a multiple of 8 (NB = DATA_W/8 bytes)
//   TIMEOUT_CYC  255  maximum cycles from dp_start to dp_done before abort
// PORTS
//   clk         in   1       system clock
//   rst_n       in   1       reset, synchronous, active-low
//   ena         in   1       design enable; low = freeze FSM, ignore strobe/ack edges
//   in_byte     in   8       command/operand byte (ui_in)
//   in_stb      in   1       byte strobe, asynchronous pin (uio_in[0])
//   out_ack     in   1       result-byte acknowledge, asynchronous pin (uio_in[1])
//   out_byte    out  8       result/status byte (uo_out)
//   out_valid   out  1       out_byte holds a byte awaiting ack
//   busy        out  1       high in any state other than IDLE
//   dp_op       out  4       opcode to datapath
//   dp_a        out  DATA_W  operand A
//   dp_b        out  DATA_W  operand B
//   dp_start    out  1       one-cycle issue pulse
//   dp_done     in   1       datapath completion (one cycle or level)
//   dp_result   in   DATA_W  datapath result, valid with dp_done
// BEHAVIOUR
//   - in_stb, out_ack: 2-FF synchronisers + rising-edge detect; an edge acts 3 cycles after pin rise.
//   - Reset: state IDLE; out_byte 8'h00; out_valid, busy, dp_start 0; dp_op, dp_a, dp_b 0;
//     sticky flags (err_hdr, err_ovr, err_to) 0; chain_valid 0; synchroniser flops 0.
//   - Header: [7:4] opcode, [3:0] flags. Opcode 4'h0 = STATUS; others are datapath ops.
//   - FSM: IDLE -hdr-> LOAD_A -NB bytes-> LOAD_B -NB bytes-> ISSUE -> WAIT -> SEND -> IDLE.
//     STATUS header: IDLE -> SEND with one byte {busy,err_ovr,err_to,err_hdr,chain_valid,3'b0},
//     captured at header accept (busy bit reads 0); sticky errors clear once that byte is acked.
//   - Operand bytes MSB-first, shifted left into dp_a/dp_b.
//   - ISSUE: dp_start high exactly one cycle; WAIT begins the next cycle; dp_done ignored in ISSUE.
//   - WAIT: counter 0..TIMEOUT_CYC; dp_done latches dp_result, -> SEND. Count reaches
//     TIMEOUT_CYC without done: set err_to, return one byte 8'hEE via SEND.
//   - SEND: NB bytes MSB-first; out_valid=1 with byte stable until ack edge; next byte one
//     cycle after ack; after last ack out_valid=0 -> IDLE.
//   - Header flags nonzero (where not defined by macro): set err_hdr, stay IDLE.
//   - Strobe edge in ISSUE/WAIT/SEND: byte dropped, err_ovr set. Ack edge with out_valid=0: ignored.
//   - ena=0: state, counters, outputs hold; edges occurring while low are discarded.
//   - rst_n low mid-operation: immediate full reset next edge; pending dp_done afterward ignored.
// CONFIGURATION
//   SPU_SEQ_CHAIN_EN defined: header flag bit0 = CHAIN. With CHAIN=1 and chain_valid=1,
//     LOAD_A skipped and dp_a = previous result; chain_valid set by every successful SEND,
//     cleared by timeout/reset. CHAIN=1 with chain_valid=0: err_hdr, stay IDLE.
//   Not defined: all flag bits reserved; chain_valid reads 0.
// TESTING
//   Reset: rst_n=0 2 cycles -> out_byte=00, out_valid=0, busy=0, dp_start=0.
//   Cmd 8'h10,12,34,00,05; dp model returns 16'h1239 after 4 cyc -> one dp_start with
//     dp_a=1234, dp_b=0005, dp_op=1; out_byte 12 then 39, each held until ack.
//   dp_done never asserted -> err_to after TIMEOUT_CYC cycles, byte EE; STATUS 8'h00 -> 8'h20.
//   Strobe during WAIT -> byte dropped, err_ovr; STATUS -> 8'h40; second STATUS -> 8'h00.
//   Header 8'h12 without macro -> err_hdr, busy stays 0; ena=0 mid-LOAD_B then strobe -> ignored.
//   With SPU_SEQ_CHAIN_EN: 8'h10,..result R; then 8'h21,00,02 -> dp_a=R, dp_b=0002.

Source files
------------

// File: rtl/spu_cmd_sequencer.sv
// spu_cmd_sequencer: byte-serial command front end for the SPU datapath.
// Optional build macro SPU_SEQ_CHAIN_EN enables result chaining through header flag bit0.

module spu_cmd_sequencer #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        in_byte,
  input  logic              in_stb,
  input  logic              out_ack,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  output logic              busy,
  output logic [3:0]        dp_op,
  output logic [DATA_W-1:0] dp_a,
  output logic [DATA_W-1:0] dp_b,
  output logic              dp_start,
  input  logic              dp_done,
  input  logic [DATA_W-1:0] dp_result
);

  // state   | meaning
  // IDLE    | waiting for a header byte
  // LOAD_A  | shifting in operand A bytes, MSB first
  // LOAD_B  | shifting in operand B bytes, MSB first
  // ISSUE   | dp_start pulse cycle
  // WAIT    | waiting for dp_done, timeout counter running
  // SEND    | returning result/status bytes with ack handshake
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_SEND   = 3'd5;

  localparam int NB   = DATA_W / 8;
  localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB - 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC);

  logic [2:0]        state;
  logic [2:0]        stb_sync;
  logic [2:0]        ack_sync;
  logic              stb_edge;
  logic              ack_edge;
  logic [BC_W-1:0]   byte_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] snd_q;
  logic              snd_status;
  logic [2:0]        stat_rep;
  logic              err_hdr;
  logic              err_ovr;
  logic              err_to;
  logic              chain_q;
  logic [7:0]        status_byte;
  logic [3:0]        hdr_op;
  logic [3:0]        hdr_flags;
  logic              hdr_bad;
  logic              hdr_chain;
`ifdef SPU_SEQ_CHAIN_EN
  logic [DATA_W-1:0] res_q;
  logic              snd_result;
`endif

  function automatic logic [DATA_W-1:0] top_byte(input logic [7:0] b);
    logic [DATA_W-1:0] t;
    t = '0;
    t[DATA_W-1 -: 8] = b;
    return t;
  endfunction

  // [0],[1] form the synchroniser; [2] is the previous sample for edge detect
  assign stb_edge    = stb_sync[1] & ~stb_sync[2];
  assign ack_edge    = ack_sync[1] & ~ack_sync[2];
  assign out_byte    = snd_q[DATA_W-1 -: 8];
  assign busy        = (state != ST_IDLE);
  assign status_byte = {1'b0, err_ovr, err_to, err_hdr, chain_q, 3'b000};

  always_comb begin
    hdr_op    = in_byte[7:4];
    hdr_flags = in_byte[3:0];
    hdr_bad   = 1'b0;
    hdr_chain = 1'b0;
`ifdef SPU_SEQ_CHAIN_EN
    if (hdr_op == 4'h0) begin
      hdr_bad = (hdr_flags != 4'h0);
    end else begin
      hdr_chain = hdr_flags[0];
      hdr_bad   = (hdr_flags[3:1] != 3'b000) || (hdr_flags[0] && !chain_q);
    end
`else
    hdr_bad = (hdr_flags != 4'h0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      stb_sync   <= '0;
      ack_sync   <= '0;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      snd_q      <= '0;
      snd_status <= 1'b0;
      stat_rep   <= '0;
      out_valid  <= 1'b0;
      dp_start   <= 1'b0;
      dp_op      <= '0;
      dp_a       <= '0;
      dp_b       <= '0;
      err_hdr    <= 1'b0;
      err_ovr    <= 1'b0;
      err_to     <= 1'b0;
      chain_q    <= 1'b0;
`ifdef SPU_SEQ_CHAIN_EN
      res_q      <= '0;
      snd_result <= 1'b0;
`endif
    end else begin
      // synchronisers keep running while disabled so edges seen then are consumed
      stb_sync <= {stb_sync[1:0], in_stb};
      ack_sync <= {ack_sync[1:0], out_ack};
      dp_start <= 1'b0;
      if (ena) begin
        case (state)
          ST_IDLE: begin
            if (stb_edge) begin
              if (hdr_bad) begin
                err_hdr <= 1'b1;
              end else if (hdr_op == 4'h0) begin
                snd_q      <= top_byte(status_byte);
                stat_rep   <= {err_ovr, err_to, err_hdr};
                snd_status <= 1'b1;
`ifdef SPU_SEQ_CHAIN_EN
                snd_result <= 1'b0;
`endif
                byte_cnt   <= '0;
                out_valid  <= 1'b1;
                state      <= ST_SEND;
              end else begin
                dp_op    <= hdr_op;
                byte_cnt <= BC_LAST;
`ifdef SPU_SEQ_CHAIN_EN
                if (hdr_chain) dp_a <= res_q;
`endif
                state    <= hdr_chain ? ST_LOAD_B : ST_LOAD_A;
              end
            end
          end
          ST_LOAD_A: begin
            if (stb_edge) begin
              dp_a <= (dp_a << 8) | DATA_W'(in_byte);
              if (byte_cnt == '0) begin
                byte_cnt <= BC_LAST;
                state    <= ST_LOAD_B;
              end else begin
                byte_cnt <= byte_cnt - 1'b1;
              end
            end
          end
          ST_LOAD_B: begin
            if (stb_edge) begin
              dp_b <= (dp_b << 8) | DATA_W'(in_byte);
              if (byte_cnt == '0) begin
                dp_start <= 1'b1;
                state    <= ST_ISSUE;
              end else begin
                byte_cnt <= byte_cnt - 1'b1;
              end
            end
          end
          ST_ISSUE: begin
            if (stb_edge) err_ovr <= 1'b1;
            to_cnt <= TO_LOAD;
            state  <= ST_WAIT;
          end
          ST_WAIT: begin
            if (stb_edge) err_ovr <= 1'b1;
            if (dp_done) begin
              snd_q      <= dp_result;
              snd_status <= 1'b0;
`ifdef SPU_SEQ_CHAIN_EN
              res_q      <= dp_result;
              snd_result <= 1'b1;
`endif
              byte_cnt   <= BC_LAST;
              out_valid  <= 1'b1;
              state      <= ST_SEND;
            end else if (to_cnt == '0) begin
              err_to     <= 1'b1;
              chain_q    <= 1'b0;
              snd_q      <= top_byte(8'hEE);
              snd_status <= 1'b0;
`ifdef SPU_SEQ_CHAIN_EN
              snd_result <= 1'b0;
`endif
              byte_cnt   <= '0;
              out_valid  <= 1'b1;
              state      <= ST_SEND;
            end else begin
              to_cnt <= to_cnt - 1'b1;
            end
          end
          ST_SEND: begin
            if (ack_edge && out_valid) begin
              snd_q <= snd_q << 8;
              if (byte_cnt == '0) begin
                out_valid <= 1'b0;
                state     <= ST_IDLE;
                // only flags that were actually reported get cleared
                if (snd_status) begin
                  err_ovr <= err_ovr & ~stat_rep[2];
                  err_to  <= err_to  & ~stat_rep[1];
                  err_hdr <= err_hdr & ~stat_rep[0];
                end
`ifdef SPU_SEQ_CHAIN_EN
                if (snd_result) chain_q <= 1'b1;
`endif
              end else begin
                byte_cnt <= byte_cnt - 1'b1;
              end
            end
            if (stb_edge) err_ovr <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
